// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each grant forwards up to MAX_BURST beats, with one IDLE bubble between grants.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;

    logic [DATA_WIDTH-1:0] slice [NUM_REQ];
    logic                  owner_vld;
    logic                  last_beat;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester after 'last', wrapping modulo NUM_REQ; scanned
    // downward so the nearest candidate overwrites the farther ones.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDW-1:0]     last);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] cand;
        pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDW'((int'(last) + k) % NUM_REQ);
            if (v[cand]) pick = cand;
        end
        return pick;
    endfunction

    assign owner_vld = req_valid[owner_q];
    assign last_beat = (beat_cnt_q == CNTW'(MAX_BURST - 1));

    assign busy      = (state_q == GRANT);
    assign grant_id  = owner_q;
    assign wdata     = slice[owner_q];
    // wfull gates the write combinationally so a full FIFO is never written.
    assign winc      = busy && owner_vld && !wfull;
    assign req_ready = (busy && !wfull) ? (NUM_REQ'(1) << owner_q) : '0;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d    = GRANT;
                    owner_d    = rr_pick(req_valid, last_q);
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (winc) beat_cnt_d = beat_cnt_q + CNTW'(1);
                if (!owner_vld || (winc && last_beat)) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_q     <= IDW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and random bench for fifo_write_arbiter with a transaction-level
// reference model and per-producer in-order scoreboard.
module tb_fifo_write_arbiter;

    localparam int DW  = 8;
    localparam int NR  = 4;
    localparam int MB  = 4;
    localparam int IDW = $clog2(NR);

    logic              wclk = 1'b0;
    logic              wrst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              wfull;
    logic              winc;
    logic [DW-1:0]     wdata;
    logic [IDW-1:0]    grant_id;
    logic              busy;

    always #5 wclk = ~wclk;

    fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
        .grant_id(grant_id), .busy(busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: who owns the port, who was served last, beats this grant.
    bit             m_busy;
    logic [IDW-1:0] m_owner;
    logic [IDW-1:0] m_last;
    int             m_beats;
    logic [DW-1:0]  nxt [NR];
    int             m_acc [NR];
    int             d_acc [NR];
    int             exp_total;
    int             total_winc;

    logic [DW-1:0]  wlog [$];
    int             glog [$];
    int             gaps [$];
    int             gap;
    bit             prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_first(input logic [NR-1:0] v, input logic [IDW-1:0] last);
        logic [IDW-1:0] ix;
        for (int k = 1; k <= NR; k++) begin
            ix = IDW'((int'(last) + k) % NR);
            if (v[ix]) return int'(ix);
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = '0;
        m_last  = IDW'(NR - 1);
        m_beats = 0;
    endtask

    task automatic clr_logs();
        wlog.delete();
        glog.delete();
        gaps.delete();
        gap       = 0;
        prev_busy = 1'b0;
    endtask

    task automatic pack();
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = nxt[i];
    endtask

    // One clock: present inputs, check outputs at negedge, advance model.
    task automatic step();
        logic [NR-1:0] exp_ready;
        logic          exp_winc;
        int            f;
        pack();
        @(negedge wclk);
        exp_winc  = m_busy && req_valid[m_owner] && !wfull;
        exp_ready = (m_busy && !wfull) ? (NR'(1) << m_owner) : '0;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("winc", 32'(winc), 32'(exp_winc));
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        if (m_busy) chk("grant_id", 32'(grant_id), 32'(m_owner));
        if (exp_winc) chk("wdata", 32'(wdata), 32'(nxt[m_owner]));
        if (winc) begin
            wlog.push_back(wdata);
            total_winc++;
            d_acc[grant_id]++;
        end
        if (!busy) gap++;
        else if (!prev_busy) begin
            glog.push_back(int'(grant_id));
            gaps.push_back(gap);
            gap = 0;
        end
        prev_busy = busy;
        if (!m_busy) begin
            f = rr_first(req_valid, m_last);
            if (f >= 0) begin
                m_busy  = 1'b1;
                m_owner = IDW'(f);
                m_beats = 0;
            end
        end else begin
            if (exp_winc) begin
                nxt[m_owner]++;
                m_acc[m_owner]++;
                m_beats++;
                exp_total++;
            end
            if (!req_valid[m_owner] || (exp_winc && m_beats == MB)) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end
        end
        @(posedge wclk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] s;
        int            exp_g [5];

        wrst_n    = 1'b0;
        req_valid = '0;
        wfull     = 1'b0;
        nxt[0] = 8'h00; nxt[1] = 8'h40; nxt[2] = 8'h10; nxt[3] = 8'hC0;
        for (int i = 0; i < NR; i++) begin
            m_acc[i] = 0;
            d_acc[i] = 0;
        end
        exp_total  = 0;
        total_winc = 0;
        model_reset();
        clr_logs();
        pack();
        #12;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_winc", 32'(winc), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_grant_id", 32'(grant_id), 32'(0));
        chk("rst_wdata", 32'(wdata), 32'(nxt[0]));
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;

        // Single producer 2: two bursts of four with one bubble between.
        req_valid = 4'b0100;
        repeat (10) step();
        req_valid = '0;
        step();
        chk("single_beats", 32'(wlog.size()), 32'(8));
        for (int k = 0; k < 8 && k < wlog.size(); k++)
            chk("single_data", 32'(wlog[k]), 32'(8'h10 + k));
        chk("single_grants", 32'(glog.size()), 32'(2));
        for (int k = 0; k < glog.size(); k++) chk("single_gid", 32'(glog[k]), 32'(2));
        for (int k = 0; k < gaps.size(); k++) chk("single_gap", 32'(gaps[k]), 32'(1));

        // Full stall mid-burst on producer 1.
        clr_logs();
        s = nxt[1];
        req_valid = 4'b0010;
        repeat (3) step();
        wfull = 1'b1;
        repeat (3) begin
            pack();
            #1;
            chk("stall_winc", 32'(winc), 32'(0));
            chk("stall_ready", 32'(req_ready), 32'(0));
            chk("stall_busy", 32'(busy), 32'(1));
            chk("stall_gid", 32'(grant_id), 32'(1));
            step();
        end
        wfull = 1'b0;
        repeat (2) step();
        req_valid = '0;
        step();
        chk("stall_beats", 32'(wlog.size()), 32'(4));
        for (int k = 0; k < 4 && k < wlog.size(); k++)
            chk("stall_data", 32'(wlog[k]), 32'(DW'(s + k)));

        // Asynchronous reset in the middle of a burst.
        req_valid = 4'b1000;
        repeat (2) step();
        #2;
        wrst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'(0));
        chk("async_winc", 32'(winc), 32'(0));
        chk("async_ready", 32'(req_ready), 32'(0));
        chk("async_gid", 32'(grant_id), 32'(0));
        model_reset();
        @(posedge wclk);
        #1;
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;

        // Round robin with all producers valid, starting from reset priority.
        clr_logs();
        req_valid = 4'b1111;
        repeat (25) step();
        exp_g = '{0, 1, 2, 3, 0};
        chk("rr_grants", 32'(glog.size()), 32'(5));
        for (int k = 0; k < 5 && k < glog.size(); k++)
            chk("rr_order", 32'(glog[k]), 32'(exp_g[k]));
        for (int k = 0; k < gaps.size(); k++) chk("rr_gap", 32'(gaps[k]), 32'(1));
        chk("rr_beats", 32'(wlog.size()), 32'(20));

        // Owner 1 drops valid after two beats while 3 waits.
        clr_logs();
        req_valid = 4'b1010;
        repeat (3) step();
        req_valid = 4'b1000;
        repeat (3) step();
        chk("drop_grants", 32'(glog.size()), 32'(2));
        if (glog.size() == 2) begin
            chk("drop_first", 32'(glog[0]), 32'(1));
            chk("drop_next", 32'(glog[1]), 32'(3));
        end
        chk("drop_beats", 32'(wlog.size()), 32'(3));

        // Random valid / wfull traffic.
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < NR; i++)
                if ($urandom_range(0, 3) == 0) req_valid[i] = ~req_valid[i];
            wfull = ($urandom_range(0, 3) == 0);
            step();
        end
        chk("total_beats", 32'(total_winc), 32'(exp_total));
        for (int i = 0; i < NR; i++) chk("per_prod_beats", 32'(d_acc[i]), 32'(m_acc[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
